song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
Programmable, parametrised auto-play sequencer for the FPGA piano.
- Steps through a song table of {note, duration, last} entries, timed by a beat-tick enable.
- Drives the 4-bit note code to the tone generator and the 8-bit note LED bar.
- Holds NUM_SONGS selectable songs in a writable table. Supports multi-beat notes, optional inter-note rests, loop, pause/resume and stop.
- Single clock domain; the beat is an enable, not a clock.

Parameters:
- NUM_SONGS, 2, number of song slots; must be a power of 2, ≥2.
- SONG_DEPTH, 32, entries per song slot; must be a power of 2, ≥2.
- DUR_W, 3, duration field width; note length in beats = dur+1.
- GAP_BEATS, 1, rest beats (note=none) inserted after every entry; 0 disables. Range 0..15.

Ports:
- clk  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- beat_tick  in  1  one-clk pulse per beat
- start  in  1  pulse: (re)start the selected song from entry 0
- stop  in  1  pulse: abort to IDLE
- pause  in  1  pulse: toggle pause
- loop_en  in  1  level: restart the song at its end instead of finishing
- song_sel  in  $clog2(NUM_SONGS)  song slot; sampled on start only
- wr_en  in  1  table write strobe
- wr_addr  in  $clog2(NUM_SONGS*SONG_DEPTH)  {slot, index}
- wr_data  in  DUR_W+5  {last, dur, note[3:0]}
- note  out  4  current note code
- Led  out  8  one-hot note display
- playing  out  1  high in PLAY, GAP or PAUSED
- paused  out  1  high in PAUSED
- done  out  1  one-clk pulse at a non-looped song end
- step_idx  out  $clog2(SONG_DEPTH)  current entry index

Behaviour:
- Note codes: C5=0, B=1, A=2, G=3, F=4, E=5, D=6, C4=7, none=8.
- Led: code k in 0..7 gives Led[7-k]=1 and all other bits 0. Code 8 gives 8'h00. Codes 9..15 give 8'hFF.
- note and Led are registered; Led always matches note in the same cycle.
- Reset values: note=8, Led=0, playing=0, paused=0, done=0, step_idx=0, state=IDLE.
- The table is not reset. Software writes it before start.
- Writes take effect on the next clk. An entry is read when it is entered, so rewriting a future entry mid-song is honoured.
- States: IDLE, PLAY, GAP, PAUSED, DONE.
- IDLE: note=none.
  - start: latch song_sel, step_idx=0, load beat counter with dur(entry0), go to PLAY.
  - note shows entry0 on the cycle after the start pulse (1-clk latency).
- PLAY: note=entry note.
  - Each beat_tick decrements the counter. A tick arriving when the counter is 0 ends the entry.
  - The entry therefore lasts exactly dur+1 ticks.
  - A beat_tick in the same cycle as the state entry is not counted.
- End of entry:
  - If GAP_BEATS>0, go to GAP with note=none and count GAP_BEATS ticks the same way.
  - Otherwise advance immediately.
- Advance:
  - If last=1 or step_idx==SONG_DEPTH-1: with loop_en=1, set step_idx=0 and go to PLAY; otherwise go to DONE.
  - Otherwise step_idx+1 and go to PLAY.
  - The new entry's note appears on the cycle after the terminating tick.
- DONE: single cycle. done=1, note=none, then IDLE.
- PAUSED:
  - Entered from PLAY or GAP on pause.
  - note=none; beat counter and step_idx are frozen; beat_tick is ignored.
  - pause returns to the saved state (PLAY or GAP) with the remaining count intact and the note restored.
  - pause in IDLE or DONE is ignored.
- Priority for same-cycle events: RESET > stop > start > pause > beat_tick.
  - stop from any state goes to IDLE: note=none, step_idx=0, done not asserted.
  - start while playing or paused restarts from entry 0 of the newly sampled song_sel and clears paused.
- loop_en is sampled only at the advance decision.
- The index wraps only by the loop rule; step_idx never exceeds SONG_DEPTH-1.
- RESET asserted mid-song forces the reset values immediately, asynchronously.

Decomposition:
- Shared package piano_pkg:
  - note code localparams (C5..C4, NOTE_NONE=8)
  - LED one-hot localparams
  - state encoding
  - entry field offsets
- Sub-module song_table: NUM_SONGS*SONG_DEPTH x (DUR_W+5) register array with synchronous write port and combinational read port.
- The FSM, counters and Led decode live in song_sequencer.

Test Plan:
1. Reset, then load slot0 = {E d0, F d0, G d2 last}, GAP_BEATS=1, start, tick every 4 clk:
   - note sequence: E(1 tick), none(1), F(1), none(1), G(3), none(1).
   - done pulses once, then IDLE, note=8, Led=0.
   - Led during G = 8'b0001_0000.
2. Same song with loop_en=1:
   - after the last rest, note returns to E with step_idx=0.
   - done never asserted over 3 loops.
3. Pause during G with 2 ticks remaining, apply 5 ticks, then pause again:
   - note=8 and paused=1 while paused.
   - G resumes for exactly 2 more ticks.
4. stop and pause asserted in the same cycle mid-song:
   - IDLE, playing=0, paused=0, step_idx=0, no done.
5. Fill slot1 with 32 entries, none with last set, song_sel=1, GAP_BEATS=0:
   - entry 31 ends the song (index boundary), done=1.
   - start and beat_tick in the same cycle: tick not counted, entry0 lasts dur+1 subsequent ticks.
6. Write entry 2 while entry 1 is playing:
   - the new value plays.
   - assert RESET mid-note: outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the FPGA piano: note codes, LED patterns, sequencer
// state encoding and song-table entry layout.
package piano_pkg;

    localparam logic [3:0] NOTE_C5   = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_A    = 4'd2;
    localparam logic [3:0] NOTE_G    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_D    = 4'd6;
    localparam logic [3:0] NOTE_C4   = 4'd7;
    localparam logic [3:0] NOTE_NONE = 4'd8;

    localparam logic [7:0] LED_C5      = 8'b1000_0000;
    localparam logic [7:0] LED_B       = 8'b0100_0000;
    localparam logic [7:0] LED_A       = 8'b0010_0000;
    localparam logic [7:0] LED_G       = 8'b0001_0000;
    localparam logic [7:0] LED_F       = 8'b0000_1000;
    localparam logic [7:0] LED_E       = 8'b0000_0100;
    localparam logic [7:0] LED_D       = 8'b0000_0010;
    localparam logic [7:0] LED_C4      = 8'b0000_0001;
    localparam logic [7:0] LED_NONE    = 8'h00;
    localparam logic [7:0] LED_INVALID = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_PAUSED,
        ST_DONE
    } state_e;

    // Entry layout is {last, dur[DUR_W-1:0], note[3:0]}.
    localparam int ENTRY_NOTE_LSB = 0;
    localparam int ENTRY_DUR_LSB  = 4;

    function automatic int entry_last_bit(input int dur_w);
        return dur_w + 4;
    endfunction

    function automatic logic [7:0] led_decode(input logic [3:0] code);
        case (code)
            NOTE_C5:   return LED_C5;
            NOTE_B:    return LED_B;
            NOTE_A:    return LED_A;
            NOTE_G:    return LED_G;
            NOTE_F:    return LED_F;
            NOTE_E:    return LED_E;
            NOTE_D:    return LED_D;
            NOTE_C4:   return LED_C4;
            NOTE_NONE: return LED_NONE;
            default:   return LED_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, table-write and display signals between the piano controller and
// the song sequencer.
interface song_sequencer_if #(
    parameter int NUM_SONGS  = 2,
    parameter int SONG_DEPTH = 32,
    parameter int DUR_W      = 3
);
    localparam int SEL_W  = $clog2(NUM_SONGS);
    localparam int ADDR_W = $clog2(NUM_SONGS * SONG_DEPTH);
    localparam int IDX_W  = $clog2(SONG_DEPTH);
    localparam int DATA_W = DUR_W + 5;

    logic              beat_tick;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [SEL_W-1:0]  song_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        note;
    logic [7:0]        Led;
    logic              playing;
    logic              paused;
    logic              done;
    logic [IDX_W-1:0]  step_idx;

    modport master (
        output beat_tick, start, stop, pause, loop_en, song_sel,
               wr_en, wr_addr, wr_data,
        input  note, Led, playing, paused, done, step_idx
    );

    modport slave (
        input  beat_tick, start, stop, pause, loop_en, song_sel,
               wr_en, wr_addr, wr_data,
        output note, Led, playing, paused, done, step_idx
    );

endinterface

// File: rtl/song_table.sv
// Writable song table: one synchronous write port, one combinational read
// port, addressed as {slot, index}.
module song_table #(
    parameter int NUM_SONGS  = 2,
    parameter int SONG_DEPTH = 32,
    parameter int DUR_W      = 3
) (
    input  logic                                    clk,
    input  logic                                    wr_en_i,
    input  logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0] wr_addr_i,
    input  logic [DUR_W+4:0]                        wr_data_i,
    input  logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0] rd_addr_i,
    output logic [DUR_W+4:0]                        rd_data_o
);
    localparam int ENTRIES = NUM_SONGS * SONG_DEPTH;

    logic [DUR_W+4:0] mem_q [ENTRIES];

    // NOTE: the array has no reset on purpose; software loads it before any
    // start, and a reset network on every cell would only cost routing.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/song_sequencer.sv
// Auto-play song sequencer: walks a song-table slot entry by entry on beat
// ticks, with rests, looping, pause/resume and stop.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int NUM_SONGS  = 2,
    parameter int SONG_DEPTH = 32,
    parameter int DUR_W      = 3,
    parameter int GAP_BEATS  = 1
) (
    input  logic           clk,
    input  logic           RESET,
    song_sequencer_if.slave bus
);
    localparam int SEL_W    = $clog2(NUM_SONGS);
    localparam int IDX_W    = $clog2(SONG_DEPTH);
    localparam int ADDR_W   = $clog2(NUM_SONGS * SONG_DEPTH);
    localparam int DATA_W   = DUR_W + 5;
    localparam int CNT_W    = (DUR_W > 4) ? DUR_W : 4;
    localparam int LAST_BIT = entry_last_bit(DUR_W);
    localparam int GAP_LOAD = (GAP_BEATS > 0) ? GAP_BEATS - 1 : 0;

    state_e            state_q, resume_q;
    logic [SEL_W-1:0]  song_q;
    logic [IDX_W-1:0]  step_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        cur_note_q, note_q;
    logic              cur_last_q;
    logic [7:0]        led_q;
    logic              playing_q, paused_q, done_q;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  next_idx;
    logic              is_end;
    logic [3:0]        rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic              rd_last;

    song_table #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_DEPTH(SONG_DEPTH),
        .DUR_W     (DUR_W)
    ) u_table (
        .clk      (clk),
        .wr_en_i  (bus.wr_en),
        .wr_addr_i(bus.wr_addr),
        .wr_data_i(bus.wr_data),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    // The single read port serves either entry 0 of the requested slot on
    // start, or the entry the current one would advance into.
    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        is_end   = cur_last_q || (step_q == IDX_W'(SONG_DEPTH - 1));
        next_idx = is_end ? '0 : step_q + IDX_W'(1);
        if (bus.start) begin
            rd_addr = {bus.song_sel, {IDX_W{1'b0}}};
        end else begin
            rd_addr = {song_q, next_idx};
        end
        rd_note = rd_data[ENTRY_NOTE_LSB +: 4];
        rd_dur  = rd_data[ENTRY_DUR_LSB +: DUR_W];
        rd_last = rd_data[LAST_BIT];
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            resume_q   <= ST_PLAY;
            song_q     <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            cur_note_q <= NOTE_NONE;
            cur_last_q <= 1'b0;
            note_q     <= NOTE_NONE;
            led_q      <= LED_NONE;
            playing_q  <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state_q   <= ST_IDLE;
                step_q    <= '0;
                note_q    <= NOTE_NONE;
                led_q     <= LED_NONE;
                playing_q <= 1'b0;
                paused_q  <= 1'b0;
            end else if (bus.start) begin
                song_q     <= bus.song_sel;
                step_q     <= '0;
                cnt_q      <= CNT_W'(rd_dur);
                cur_note_q <= rd_note;
                cur_last_q <= rd_last;
                note_q     <= rd_note;
                led_q      <= led_decode(rd_note);
                state_q    <= ST_PLAY;
                playing_q  <= 1'b1;
                paused_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_PLAY, ST_GAP: begin
                        if (bus.pause) begin
                            resume_q <= state_q;
                            state_q  <= ST_PAUSED;
                            note_q   <= NOTE_NONE;
                            led_q    <= LED_NONE;
                            paused_q <= 1'b1;
                        end else if (bus.beat_tick) begin
                            if (cnt_q != '0) begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end else if (state_q == ST_PLAY && GAP_BEATS > 0) begin
                                state_q <= ST_GAP;
                                cnt_q   <= CNT_W'(GAP_LOAD);
                                note_q  <= NOTE_NONE;
                                led_q   <= LED_NONE;
                            end else if (is_end && !bus.loop_en) begin
                                state_q   <= ST_DONE;
                                done_q    <= 1'b1;
                                playing_q <= 1'b0;
                                note_q    <= NOTE_NONE;
                                led_q     <= LED_NONE;
                            end else begin
                                step_q     <= next_idx;
                                cnt_q      <= CNT_W'(rd_dur);
                                cur_note_q <= rd_note;
                                cur_last_q <= rd_last;
                                note_q     <= rd_note;
                                led_q      <= led_decode(rd_note);
                                state_q    <= ST_PLAY;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.pause) begin
                            state_q  <= resume_q;
                            paused_q <= 1'b0;
                            if (resume_q == ST_PLAY) begin
                                note_q <= cur_note_q;
                                led_q  <= led_decode(cur_note_q);
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.note     = note_q;
    assign bus.Led      = led_q;
    assign bus.playing  = playing_q;
    assign bus.paused   = paused_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two instances (GAP_BEATS=1 and 0) share the same
// stimulus and are compared every cycle against a tick-counting song model.
module tb_song_sequencer;
    import piano_pkg::*;

    localparam int NS = 2, SD = 32, DW = 3;
    localparam int AW = 6, IW = 5, SW = 1, DATW = DW + 5;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    logic            beat_tick, start, stop, pause, loop_en, wr_en;
    logic [SW-1:0]   song_sel;
    logic [AW-1:0]   wr_addr;
    logic [DATW-1:0] wr_data;

    song_sequencer_if #(.NUM_SONGS(NS), .SONG_DEPTH(SD), .DUR_W(DW)) bus_g1 ();
    song_sequencer_if #(.NUM_SONGS(NS), .SONG_DEPTH(SD), .DUR_W(DW)) bus_g0 ();

    assign bus_g1.beat_tick = beat_tick;  assign bus_g0.beat_tick = beat_tick;
    assign bus_g1.start     = start;      assign bus_g0.start     = start;
    assign bus_g1.stop      = stop;       assign bus_g0.stop      = stop;
    assign bus_g1.pause     = pause;      assign bus_g0.pause     = pause;
    assign bus_g1.loop_en   = loop_en;    assign bus_g0.loop_en   = loop_en;
    assign bus_g1.song_sel  = song_sel;   assign bus_g0.song_sel  = song_sel;
    assign bus_g1.wr_en     = wr_en;      assign bus_g0.wr_en     = wr_en;
    assign bus_g1.wr_addr   = wr_addr;    assign bus_g0.wr_addr   = wr_addr;
    assign bus_g1.wr_data   = wr_data;    assign bus_g0.wr_data   = wr_data;

    song_sequencer #(.NUM_SONGS(NS), .SONG_DEPTH(SD), .DUR_W(DW), .GAP_BEATS(1)) dut_g1 (
        .clk(clk), .RESET(RESET), .bus(bus_g1.slave));
    song_sequencer #(.NUM_SONGS(NS), .SONG_DEPTH(SD), .DUR_W(DW), .GAP_BEATS(0)) dut_g0 (
        .clk(clk), .RESET(RESET), .bus(bus_g0.slave));

    // Index 0 is the GAP_BEATS=1 instance, index 1 the GAP_BEATS=0 instance.
    logic [3:0]    obs_note [2];
    logic [7:0]    obs_led  [2];
    logic          obs_play [2], obs_paus [2], obs_done [2];
    logic [IW-1:0] obs_step [2];
    assign obs_note[0] = bus_g1.note;     assign obs_note[1] = bus_g0.note;
    assign obs_led[0]  = bus_g1.Led;      assign obs_led[1]  = bus_g0.Led;
    assign obs_play[0] = bus_g1.playing;  assign obs_play[1] = bus_g0.playing;
    assign obs_paus[0] = bus_g1.paused;   assign obs_paus[1] = bus_g0.paused;
    assign obs_done[0] = bus_g1.done;     assign obs_done[1] = bus_g0.done;
    assign obs_step[0] = bus_g1.step_idx; assign obs_step[1] = bus_g0.step_idx;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_led(input logic [3:0] n);
        logic [7:0] one;
        one = 8'd1;
        if (n < 4'd8) return one << (7 - int'(n));
        if (n == 4'd8) return 8'h00;
        return 8'hFF;
    endfunction

    function automatic logic [DATW-1:0] enc(input logic last, input int dur, input logic [3:0] n);
        logic [DW-1:0] d;
        d = dur[DW-1:0];
        return {last, d, n};
    endfunction

    // Song model: a note segment lasts dur+1 ticks, a rest segment GAP ticks.
    logic [DATW-1:0] m_mem [NS*SD];
    bit         m_active [2], m_paused [2], m_in_gap [2], m_done [2], m_idx_ok [2], m_last [2];
    int         m_idx [2], m_slot [2], m_rem [2];
    logic [3:0] m_note [2];
    int         done_cnt [2];
    bit         chk_en = 1'b0;

    task automatic m_enter(input int g, input int i);
        logic [DATW-1:0] e;
        e = m_mem[m_slot[g]*SD + i];
        m_idx[g]    = i;
        m_note[g]   = e[3:0];
        m_last[g]   = e[DW+4];
        m_rem[g]    = int'(e[DW+3:4]) + 1;
        m_in_gap[g] = 1'b0;
    endtask

    task automatic m_step(input int g);
        int gap;
        gap = (g == 0) ? 1 : 0;
        m_done[g] = 1'b0;
        if (stop) begin
            m_active[g] = 1'b0; m_paused[g] = 1'b0; m_in_gap[g] = 1'b0;
            m_idx[g] = 0; m_idx_ok[g] = 1'b1;
        end else if (start) begin
            m_slot[g] = int'(song_sel);
            m_enter(g, 0);
            m_active[g] = 1'b1; m_paused[g] = 1'b0; m_idx_ok[g] = 1'b1;
        end else if (m_active[g]) begin
            if (pause) begin
                m_paused[g] = !m_paused[g];
            end else if (!m_paused[g] && beat_tick) begin
                m_rem[g]--;
                if (m_rem[g] == 0) begin
                    if (!m_in_gap[g] && gap > 0) begin
                        m_in_gap[g] = 1'b1;
                        m_rem[g] = gap;
                    end else if (m_last[g] || m_idx[g] == SD - 1) begin
                        if (loop_en) m_enter(g, 0);
                        else begin
                            m_active[g] = 1'b0; m_in_gap[g] = 1'b0;
                            m_done[g] = 1'b1; m_idx_ok[g] = 1'b0;
                        end
                    end else begin
                        m_enter(g, m_idx[g] + 1);
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge RESET);
        if (RESET) begin
            for (int g = 0; g < 2; g++) begin
                m_active[g] = 1'b0; m_paused[g] = 1'b0; m_in_gap[g] = 1'b0;
                m_done[g] = 1'b0; m_idx[g] = 0; m_idx_ok[g] = 1'b1;
            end
        end else begin
            for (int g = 0; g < 2; g++) m_step(g);
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && !RESET) begin
            for (int g = 0; g < 2; g++) begin
                logic [3:0] en;
                en = (m_active[g] && !m_paused[g] && !m_in_gap[g]) ? m_note[g] : NOTE_NONE;
                check($sformatf("note[%0d]", g), obs_note[g], en);
                check($sformatf("led[%0d]", g), obs_led[g], exp_led(en));
                check($sformatf("playing[%0d]", g), obs_play[g], m_active[g]);
                check($sformatf("paused[%0d]", g), obs_paus[g], m_active[g] && m_paused[g]);
                check($sformatf("done[%0d]", g), obs_done[g], m_done[g]);
                if (m_active[g] || m_idx_ok[g])
                    check($sformatf("step[%0d]", g), obs_step[g], m_idx[g]);
                if (obs_done[g] === 1'b1) done_cnt[g]++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        beat_tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            repeat (3) cyc();
            beat_tick = 1'b1;
            cyc();
        end
    endtask

    task automatic wr(input int addr, input logic [DATW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = d;
        cyc();
    endtask

    initial begin
        int d0, d1, total;
        int durs [SD];
        RESET = 1'b1;
        beat_tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
        loop_en = 1'b0; song_sel = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_note", bus_g1.note, NOTE_NONE);
        check("rst_led", bus_g1.Led, 8'h00);
        check("rst_playing", bus_g1.playing, 1'b0);
        check("rst_step", bus_g1.step_idx, 0);
        RESET = 1'b0;
        chk_en = 1'b1;

        for (int a = 0; a < NS*SD; a++) wr(a, enc(1'b0, 0, 4'(a % 9)));
        wr(0, enc(1'b0, 0, NOTE_E));
        wr(1, enc(1'b0, 0, NOTE_F));
        wr(2, enc(1'b1, 2, NOTE_G));

        // 1: single play with rests
        d0 = done_cnt[0];
        start = 1'b1; cyc();
        check("t1_first_E", bus_g1.note, NOTE_E);
        ticks(4);
        check("t1_G_note", bus_g1.note, NOTE_G);
        check("t1_G_led", bus_g1.Led, 8'b0001_0000);
        ticks(4);
        repeat (2) cyc();
        check("t1_done_once", done_cnt[0] - d0, 1);
        check("t1_idle_note", bus_g1.note, NOTE_NONE);
        check("t1_idle_led", bus_g1.Led, 8'h00);

        // 2: looping never finishes
        loop_en = 1'b1;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        start = 1'b1; cyc();
        ticks(8);
        check("t2_wrap_note", bus_g1.note, NOTE_E);
        check("t2_wrap_step", bus_g1.step_idx, 0);
        ticks(16);
        check("t2_no_done_g1", done_cnt[0] - d0, 0);
        check("t2_no_done_g0", done_cnt[1] - d1, 0);
        stop = 1'b1; cyc();
        loop_en = 1'b0;

        // 3: pause with two G ticks left
        start = 1'b1; cyc();
        ticks(5);
        pause = 1'b1; cyc();
        check("t3_paused", bus_g1.paused, 1'b1);
        check("t3_pause_note", bus_g1.note, NOTE_NONE);
        ticks(5);
        check("t3_frozen_note", bus_g1.note, NOTE_NONE);
        check("t3_frozen_step", bus_g1.step_idx, 2);
        pause = 1'b1; cyc();
        check("t3_resume_G", bus_g1.note, NOTE_G);
        ticks(1);
        check("t3_G_left1", bus_g1.note, NOTE_G);
        ticks(1);
        check("t3_G_over", bus_g1.note, NOTE_NONE);
        check("t3_still_play", bus_g1.playing, 1'b1);
        stop = 1'b1; cyc();

        // 4: stop beats pause in the same cycle
        start = 1'b1; cyc();
        ticks(2);
        d0 = done_cnt[0];
        stop = 1'b1; pause = 1'b1; cyc();
        check("t4_playing", bus_g1.playing, 1'b0);
        check("t4_paused", bus_g1.paused, 1'b0);
        check("t4_step", bus_g1.step_idx, 0);
        repeat (2) cyc();
        check("t4_no_done", done_cnt[0] - d0, 0);

        // 5: full 32-entry slot, no rests, start coincident with a tick
        total = 0;
        for (int i = 0; i < SD; i++) begin
            durs[i] = (i == 0) ? 1 : int'($urandom_range(0, 1));
            total += durs[i] + 1;
            wr(SD + i, enc(1'b0, durs[i], 4'($urandom_range(0, 7))));
        end
        song_sel = 1'b1;
        start = 1'b1; beat_tick = 1'b1; cyc();
        check("t5_e0_start", bus_g0.step_idx, 0);
        ticks(1);
        check("t5_e0_held", bus_g0.step_idx, 0);
        ticks(1);
        check("t5_e1", bus_g0.step_idx, 1);
        ticks(total - 3);
        check("t5_last_idx", bus_g0.step_idx, SD - 1);
        check("t5_last_play", bus_g0.playing, 1'b1);
        ticks(1);
        check("t5_done", bus_g0.done, 1'b1);
        check("t5_stopped", bus_g0.playing, 1'b0);
        stop = 1'b1; cyc();
        song_sel = 1'b0;

        // 6: rewrite a future entry, then reset mid-note
        start = 1'b1; cyc();
        ticks(2);
        check("t6_on_F", bus_g1.note, NOTE_F);
        wr(2, enc(1'b1, 0, NOTE_C4));
        ticks(2);
        check("t6_new_note", bus_g1.note, NOTE_C4);
        check("t6_new_led", bus_g1.Led, 8'b0000_0001);
        #2 RESET = 1'b1;
        #1;
        check("t6_async_note", bus_g1.note, NOTE_NONE);
        check("t6_async_led", bus_g1.Led, 8'h00);
        check("t6_async_play", bus_g1.playing, 1'b0);
        check("t6_async_g0", bus_g0.playing, 1'b0);
        @(posedge clk); #1;
        RESET = 1'b0;

        // Random soak against the model
        for (int c = 0; c < 4000; c++) begin
            beat_tick = ($urandom_range(0, 2) == 0);
            start     = ($urandom_range(0, 60) == 0);
            stop      = ($urandom_range(0, 200) == 0);
            pause     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 100) == 0) loop_en = $urandom_range(0, 1) != 0;
            if (start) song_sel = SW'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 15) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(0, NS*SD - 1));
                wr_data = DATW'($urandom);
                if ($urandom_range(0, 7) != 0) wr_data[DW+4] = 1'b0;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
